conv2d_wpack: RTL and testbench

CONV2D_WPACK -- requirements
Module: conv2d_wpack

---
 rtl/conv2d_wpack_pkg.sv | 25 ++
 rtl/conv2d_wpack_fifo.sv | 64 ++++++
 rtl/conv2d_wpack.sv | 235 +++++++++++++++++++++++
 tb/tb_conv2d_wpack.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_wpack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv2d_wpack_pkg                                             |
// | Description : Shared FSM state encoding and beat-size helper for the       |
// |               conv2d pixel packer / burst writer.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package conv2d_wpack_pkg;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle      = 3'd0;
    localparam logic [c_state_w-1:0] c_st_run       = 3'd1;
    localparam logic [c_state_w-1:0] c_st_go        = 3'd2;
    localparam logic [c_state_w-1:0] c_st_stream    = 3'd3;
    localparam logic [c_state_w-1:0] c_st_wait_done = 3'd4;
    localparam logic [c_state_w-1:0] c_st_over      = 3'd5;

    // Bytes carried by one write-master beat of the given bit width.
    function automatic int bytes_per_beat(input int dw);
        return dw / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv2d_wpack_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv2d_wpack_fifo                                            |
// | Description : Synchronous show-ahead beat FIFO. The head entry is always   |
// |               visible on pop_data, so it stays stable until popped.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv2d_wpack_fifo #(
    parameter int W     = 256,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full && !clr;
    assign w_pop_ok  = pop && !empty && !clr;

    // Pointer and occupancy tracking; clr discards all stored beats.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, data only, never reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/conv2d_wpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv2d_wpack                                                 |
// | Description : Packs conv2d output pixels LSB-first into DW-bit beats,      |
// |               buffers them and writes them out as bursts through a         |
// |               go/done write master. Optional statistics outputs are        |
// |               enabled by defining CONV2D_WPACK_STATS_EN.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv2d_wpack
    import conv2d_wpack_pkg::*;
#(
    parameter int AW    = 30,
    parameter int DW    = 256,
    parameter int PW    = 32,
    parameter int BURST = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          param_ena,
    input  logic [AW-1:0] param_zaddr,
    input  logic [17:0]   param_length_out,
    input  logic          pxl_ena_z,
    input  logic [PW-1:0] pxl_z,
    output logic          pxl_ready,
    output logic          wmst_ctrl_fixed_location,
    output logic [AW-1:0] wmst_ctrl_write_base,
    output logic [AW-1:0] wmst_ctrl_write_length,
    output logic          wmst_ctrl_go,
    input  logic          wmst_ctrl_done,
    output logic          wmst_user_write_buffer,
    output logic [DW-1:0] wmst_user_write_input_data,
    input  logic          wmst_user_buffer_full,
    output logic          flag_write_over,
    output logic          err_overflow
`ifdef CONV2D_WPACK_STATS_EN
    ,
    output logic [15:0]   stat_bursts,
    output logic [15:0]   stat_stall
`endif
);

    localparam int PPB    = DW / PW;
    localparam int LANE_W = (PPB > 1) ? $clog2(PPB) : 1;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] c_bpb = AW'(bytes_per_beat(DW));

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;

    logic              r_ena_q;
    logic              r_done_q;
    logic              w_start;
    logic              w_done_rise;

    logic [17:0]       r_len;
    logic [17:0]       r_pix_cnt;
    logic [LANE_W-1:0] r_lane;
    logic [DW-1:0]     r_pack;
    logic [DW-1:0]     w_beat;
    logic              w_accept;
    logic              w_last_pix;
    logic              w_beat_done;
    logic              w_all_pushed;
    logic              w_job_active;

    logic [AW-1:0]     r_wbase;
    logic [AW-1:0]     r_wlen;
    logic [CW-1:0]     r_burst_n;
    logic [CW-1:0]     r_sent;
    logic [CW-1:0]     w_burst_n;
    logic              w_pop;

    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    assign w_start      = param_ena && !r_ena_q;
    assign w_done_rise  = wmst_ctrl_done && !r_done_q;
    assign w_accept     = pxl_ena_z && pxl_ready;
    assign w_last_pix   = ((r_pix_cnt + 18'd1) == r_len);
    assign w_beat_done  = w_accept && ((r_lane == LANE_W'(PPB - 1)) || w_last_pix);
    assign w_all_pushed = (r_pix_cnt == r_len);
    assign w_burst_n    = (w_fifo_count >= CW'(BURST)) ? CW'(BURST) : w_fifo_count;
    assign w_pop        = (r_state == c_st_stream) && !wmst_user_buffer_full;

    assign wmst_ctrl_fixed_location   = 1'b0;
    assign wmst_ctrl_write_base       = r_wbase;
    assign wmst_ctrl_write_length     = r_wlen;

    // Beat being assembled: lanes below the current lane come from the packer,
    // the current lane takes the incoming pixel, lanes above are forced to zero
    // so a short final beat is zero-padded without resetting the data register.
    for (genvar k = 0; k < PPB; k++) begin : g_lane
        assign w_beat[k*PW +: PW] = (LANE_W'(k) <  r_lane) ? r_pack[k*PW +: PW] :
                                    (LANE_W'(k) == r_lane) ? pxl_z              :
                                                             {PW{1'b0}};
    end

    conv2d_wpack_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_start),
        .push      (w_beat_done),
        .push_data (w_beat),
        .pop       (w_pop),
        .pop_data  (wmst_user_write_input_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Edge detectors for job start and burst completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ena_q  <= 1'b0;
            r_done_q <= 1'b0;
        end else begin
            r_ena_q  <= param_ena;
            r_done_q <= wmst_ctrl_done;
        end
    end

    // Job length latch, accepted-pixel counter and lane pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_pix_cnt <= '0;
            r_lane    <= '0;
        end else if (w_start) begin
            r_len     <= param_length_out;
            r_pix_cnt <= '0;
            r_lane    <= '0;
        end else if (w_accept) begin
            r_pix_cnt <= r_pix_cnt + 18'd1;
            r_lane    <= w_beat_done ? '0 : r_lane + LANE_W'(1);
        end
    end

    // Packer data register, holds lanes already filled in the current beat.
    always_ff @(posedge clk) begin
        if (w_accept) r_pack <= w_beat;
    end

    // Sticky overflow: a pixel offered while not ready is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst || w_start) err_overflow <= 1'b0;
        else if (pxl_ena_z && !pxl_ready) err_overflow <= 1'b1;
    end

    // Burst bookkeeping: size latched on entry to GO, base advanced on done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbase   <= '0;
            r_wlen    <= '0;
            r_burst_n <= '0;
            r_sent    <= '0;
        end else if (w_start) begin
            r_wbase   <= param_zaddr;
            r_wlen    <= '0;
            r_burst_n <= '0;
            r_sent    <= '0;
        end else begin
            if (r_state == c_st_run && w_state_nxt == c_st_go) begin
                r_burst_n <= w_burst_n;
                r_wlen    <= AW'(w_burst_n) * c_bpb;
                r_sent    <= '0;
            end
            if (w_pop) r_sent <= r_sent + CW'(1);
            if (r_state == c_st_wait_done && w_done_rise) r_wbase <= r_wbase + r_wlen;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state logic; a job start overrides everything, aborting any job.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (w_fifo_count >= CW'(BURST) || (w_all_pushed && !w_fifo_empty))
                    w_state_nxt = c_st_go;
                else if (w_all_pushed && w_fifo_empty)
                    w_state_nxt = c_st_over;
            end
            c_st_go:        w_state_nxt = c_st_stream;
            c_st_stream: begin
                if (w_pop && (r_sent == r_burst_n - CW'(1)))
                    w_state_nxt = c_st_wait_done;
            end
            c_st_wait_done: begin
                if (w_done_rise) w_state_nxt = c_st_run;
            end
            default:        w_state_nxt = r_state;
        endcase
        if (w_start) w_state_nxt = c_st_run;
    end

    // FSM outputs; pixels are accepted throughout an active job, including
    // while a burst is in flight.
    always_comb begin
        w_job_active           = (r_state == c_st_run)    || (r_state == c_st_go) ||
                                 (r_state == c_st_stream) || (r_state == c_st_wait_done);
        wmst_ctrl_go           = (r_state == c_st_go);
        wmst_user_write_buffer = (r_state == c_st_stream);
        flag_write_over        = (r_state == c_st_over);
        pxl_ready              = w_job_active && !w_fifo_full &&
                                 (r_pix_cnt < r_len) && !w_start;
    end

`ifdef CONV2D_WPACK_STATS_EN
    // Saturating counters of issued bursts and master-stalled stream cycles.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            stat_bursts <= '0;
            stat_stall  <= '0;
        end else begin
            if (r_state == c_st_go && stat_bursts != 16'hFFFF)
                stat_bursts <= stat_bursts + 16'd1;
            if (r_state == c_st_stream && wmst_user_buffer_full && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv2d_wpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_conv2d_wpack                                              |
// | Description : Directed bench for conv2d_wpack with a behavioural write     |
// |               master that records go requests and captured beats.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_conv2d_wpack;

    localparam int AW = 30, DW = 256, PW = 32, BURST = 4, DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          param_ena;
    logic [AW-1:0] param_zaddr;
    logic [17:0]   param_length_out;
    logic          pxl_ena_z;
    logic [PW-1:0] pxl_z;
    logic          pxl_ready;
    logic          wmst_ctrl_fixed_location;
    logic [AW-1:0] wmst_ctrl_write_base;
    logic [AW-1:0] wmst_ctrl_write_length;
    logic          wmst_ctrl_go;
    logic          wmst_ctrl_done = 1'b0;
    logic          wmst_user_write_buffer;
    logic [DW-1:0] wmst_user_write_input_data;
    logic          wmst_user_buffer_full = 1'b0;
    logic          flag_write_over;
    logic          err_overflow;

    always #5 clk = ~clk;

    conv2d_wpack #(.AW(AW), .DW(DW), .PW(PW), .BURST(BURST), .DEPTH(DEPTH)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .param_ena                  (param_ena),
        .param_zaddr                (param_zaddr),
        .param_length_out           (param_length_out),
        .pxl_ena_z                  (pxl_ena_z),
        .pxl_z                      (pxl_z),
        .pxl_ready                  (pxl_ready),
        .wmst_ctrl_fixed_location   (wmst_ctrl_fixed_location),
        .wmst_ctrl_write_base       (wmst_ctrl_write_base),
        .wmst_ctrl_write_length     (wmst_ctrl_write_length),
        .wmst_ctrl_go               (wmst_ctrl_go),
        .wmst_ctrl_done             (wmst_ctrl_done),
        .wmst_user_write_buffer     (wmst_user_write_buffer),
        .wmst_user_write_input_data (wmst_user_write_input_data),
        .wmst_user_buffer_full      (wmst_user_buffer_full),
        .flag_write_over            (flag_write_over),
        .err_overflow               (err_overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [PW-1:0] pix(input logic [7:0] seed, input int j);
        return {seed, 24'(j)};
    endfunction

    function automatic logic [DW-1:0] exp_beat(input logic [7:0] seed, input int len, input int b);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW/PW; k++)
            if (b*(DW/PW) + k < len) r[k*PW +: PW] = pix(seed, b*(DW/PW) + k);
        return r;
    endfunction

    // ---------------- behavioural write master ----------------
    logic [DW-1:0] cap_q[$];
    logic [AW-1:0] go_base_q[$];
    logic [AW-1:0] go_len_q[$];
    int  rem = 0, beats_in_burst = 0, done_timer = 0;
    int  force_req = 0, force_ack = 0, stall_req = 0, stall_ack = 0, stall_left = 0;
    bit  auto_done = 1'b1, stall_bad = 1'b0, go_prev = 1'b0, go_long = 1'b0;
    logic [DW-1:0] stall_data;
    logic [AW-1:0] stall_base;

    always @(negedge clk) begin
        wmst_ctrl_done = 1'b0;
        if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) wmst_ctrl_done = 1'b1;
        end
        if (force_req != force_ack) begin
            force_ack++;
            wmst_ctrl_done = 1'b1;
        end
        if (stall_left == 0 && stall_req != stall_ack && wmst_user_write_buffer && beats_in_burst == 2) begin
            stall_ack++;
            stall_left = 5;
            stall_data = wmst_user_write_input_data;
            stall_base = wmst_ctrl_write_base;
        end
        if (stall_left > 0) begin
            wmst_user_buffer_full = 1'b1;
            stall_left--;
            if (wmst_user_write_input_data !== stall_data || wmst_ctrl_write_base !== stall_base)
                stall_bad = 1'b1;
        end else begin
            wmst_user_buffer_full = 1'b0;
        end
        if (wmst_ctrl_go) begin
            if (go_prev) go_long = 1'b1;
            go_base_q.push_back(wmst_ctrl_write_base);
            go_len_q.push_back(wmst_ctrl_write_length);
            rem = int'(wmst_ctrl_write_length >> 5);
            beats_in_burst = 0;
        end
        go_prev = wmst_ctrl_go;
        if (wmst_user_write_buffer && !wmst_user_buffer_full) begin
            cap_q.push_back(wmst_user_write_input_data);
            beats_in_burst++;
            rem--;
            if (rem == 0 && auto_done) done_timer = 3;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_job(input logic [AW-1:0] base, input int len);
        @(negedge clk);
        param_ena        = 1'b0;
        param_zaddr      = base;
        param_length_out = 18'(len);
        @(negedge clk);
        param_ena        = 1'b1;
    endtask

    task automatic send_pix(input logic [7:0] seed, input int from, input int to);
        int guard;
        for (int j = from; j < to; j++) begin
            guard = 0;
            @(negedge clk);
            while (!pxl_ready && guard < 2000) begin
                pxl_ena_z = 1'b0;
                @(negedge clk);
                guard++;
            end
            if (!pxl_ready) begin
                check("send_timeout", 0, 1);
                pxl_ena_z = 1'b0;
                return;
            end
            pxl_ena_z = 1'b1;
            pxl_z     = pix(seed, j);
        end
        @(negedge clk);
        pxl_ena_z = 1'b0;
    endtask

    task automatic wait_over(input string tag);
        int guard;
        guard = 0;
        while (!flag_write_over && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check(tag, flag_write_over, 1);
    endtask

    task automatic check_beats(input string tag, input logic [7:0] seed, input int len,
                               input int cm, input int nbeats);
        check({tag, "_nbeats"}, cap_q.size() - cm, nbeats);
        for (int b = 0; b < nbeats && cm + b < cap_q.size(); b++)
            check({tag, "_beat"}, cap_q[cm + b], exp_beat(seed, len, b));
    endtask

    int gm, cm, acc, idle, guard, lsum;
    logic [DW-1:0] b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; param_ena = 1'b0; param_zaddr = '0; param_length_out = '0;
        pxl_ena_z = 1'b0; pxl_z = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", pxl_ready, 0);
        check("rst_go", wmst_ctrl_go, 0);
        check("rst_wbuf", wmst_user_write_buffer, 0);
        check("rst_over", flag_write_over, 0);
        check("rst_err", err_overflow, 0);
        check("rst_base", wmst_ctrl_write_base, 0);
        check("rst_len", wmst_ctrl_write_length, 0);
        check("rst_fixed", wmst_ctrl_fixed_location, 0);

        // S1: 64 pixels, two full bursts
        gm = go_base_q.size(); cm = cap_q.size();
        start_job(30'h1000, 64);
        @(negedge clk);
        check("s1_not_over", flag_write_over, 0);
        send_pix(8'h11, 0, 64);
        wait_over("s1_over");
        check("s1_ngo", go_base_q.size() - gm, 2);
        if (go_base_q.size() >= gm + 2) begin
            check("s1_base0", go_base_q[gm],     30'h1000);
            check("s1_len0",  go_len_q[gm],      128);
            check("s1_base1", go_base_q[gm + 1], 30'h1080);
            check("s1_len1",  go_len_q[gm + 1],  128);
        end
        check_beats("s1", 8'h11, 64, cm, 8);

        // S2: 13 pixels, one short burst, padded second beat
        gm = go_base_q.size(); cm = cap_q.size();
        start_job(30'h2000, 13);
        send_pix(8'h22, 0, 13);
        wait_over("s2_over");
        check("s2_ngo", go_base_q.size() - gm, 1);
        if (go_base_q.size() >= gm + 1) begin
            check("s2_base", go_base_q[gm], 30'h2000);
            check("s2_len",  go_len_q[gm],  64);
        end
        check_beats("s2", 8'h22, 13, cm, 2);
        if (cap_q.size() >= cm + 2) begin
            b1 = cap_q[cm + 1];
            check("s2_pad", b1[255:160], 0);
        end

        // S3: zero length
        gm = go_base_q.size();
        start_job(30'h2500, 0);
        @(negedge clk);
        check("s3_ready", pxl_ready, 0);
        @(negedge clk);
        check("s3_over_2cyc", flag_write_over, 1);
        repeat (5) @(negedge clk);
        check("s3_ngo", go_base_q.size() - gm, 0);

        // S4: master stall of 5 cycles mid-stream
        gm = go_base_q.size(); cm = cap_q.size();
        stall_req++;
        start_job(30'h3000, 32);
        send_pix(8'h44, 0, 32);
        wait_over("s4_over");
        check("s4_stalled", stall_ack, 1);
        check("s4_stable", stall_bad, 0);
        check("s4_ngo", go_base_q.size() - gm, 1);
        check_beats("s4", 8'h44, 32, cm, 4);

        // S5: done withheld, FIFO fills, forced pixel sets overflow
        gm = go_base_q.size(); cm = cap_q.size();
        auto_done = 1'b0;
        start_job(30'h6000, 200);
        acc = 0; idle = 0;
        while (idle < 20 && acc < 200) begin
            @(negedge clk);
            if (pxl_ready) begin
                pxl_ena_z = 1'b1;
                pxl_z     = pix(8'h55, acc);
                acc++;
                idle = 0;
            end else begin
                pxl_ena_z = 1'b0;
                idle++;
            end
        end
        check("s5_accepted", acc, 160);
        check("s5_ready_low", pxl_ready, 0);
        check("s5_err_before", err_overflow, 0);
        @(negedge clk);
        pxl_ena_z = 1'b1;
        pxl_z     = 32'hDEAD_BEEF;
        @(negedge clk);
        pxl_ena_z = 1'b0;
        check("s5_err_set", err_overflow, 1);
        force_req++;
        auto_done = 1'b1;
        send_pix(8'h55, 160, 200);
        wait_over("s5_over");
        check("s5_err_sticky", err_overflow, 1);
        lsum = 0;
        for (int i = gm; i < go_len_q.size(); i++) lsum += int'(go_len_q[i]);
        check("s5_bytes", lsum, 800);
        if (go_base_q.size() >= gm + 2) begin
            check("s5_base0", go_base_q[gm],     30'h6000);
            check("s5_base1", go_base_q[gm + 1], 30'h6080);
        end
        check_beats("s5", 8'h55, 200, cm, 25);

        // S6: restart while waiting for done
        auto_done = 1'b0;
        start_job(30'h4000, 32);
        @(negedge clk);
        check("s6_err_cleared", err_overflow, 0);
        cm = cap_q.size();
        send_pix(8'h66, 0, 32);
        guard = 0;
        while (cap_q.size() < cm + 4 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("s6_first_burst", cap_q.size() - cm, 4);
        repeat (3) @(negedge clk);
        gm = go_base_q.size(); cm = cap_q.size();
        start_job(30'h5000, 16);
        force_req++;
        auto_done = 1'b1;
        repeat (2) @(negedge clk);
        check("s6_no_over", flag_write_over, 0);
        send_pix(8'h77, 0, 16);
        wait_over("s6_over");
        check("s6_ngo", go_base_q.size() - gm, 1);
        if (go_base_q.size() >= gm + 1) begin
            check("s6_base", go_base_q[gm], 30'h5000);
            check("s6_len",  go_len_q[gm],  64);
        end
        check_beats("s6", 8'h77, 16, cm, 2);

        check("go_one_cycle", go_long, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
